// File: rtl/rand_delay_gen_if.sv
// rtl/rand_delay_gen_if.sv - handshake bundle between the game control FSM and the random delay timer
interface rand_delay_gen_if #(
    parameter int DW = 16
);
    logic          rand_en;
    logic          rand_rst;
    logic          rand_tick;
    logic          busy;
    logic          done;
    logic [DW-1:0] delay_ms;
    logic [DW-1:0] ms_remaining;

    modport master (
        output rand_en,
        output rand_rst,
        input  rand_tick,
        input  busy,
        input  done,
        input  delay_ms,
        input  ms_remaining
    );

    modport slave (
        input  rand_en,
        input  rand_rst,
        output rand_tick,
        output busy,
        output done,
        output delay_ms,
        output ms_remaining
    );
endinterface

// File: rtl/rand_delay_gen.sv
// rtl/rand_delay_gen.sv - random-interval millisecond timer producing a one-cycle rand_tick
module rand_delay_gen #(
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          MIN_MS     = 1000,
    parameter int          RANGE_LOG2 = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          DW         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rand_delay_gen_if.slave   tif
);
    localparam int             TPM     = CLK_HZ / 1000;
    localparam int             PW      = (TPM > 1) ? $clog2(TPM) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(TPM - 1);
    localparam logic [DW-1:0]  MIN_D   = DW'(MIN_MS);
    // An all-zero seed would lock the LFSR up permanently
    localparam logic [15:0]    SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_FIRE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] delay_ms_q, delay_ms_d;
    logic [DW-1:0] offset;
    logic [DW-1:0] load_val;
    logic          strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            pre_q       <= '0;
            remaining_q <= '0;
            delay_ms_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pre_q       <= pre_d;
            remaining_q <= remaining_d;
            delay_ms_q  <= delay_ms_d;
        end
    end

    // Free-running so the drawn delay depends on when the player pressed start
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        offset                   = '0;
        offset[RANGE_LOG2-1:0]   = lfsr_q[RANGE_LOG2-1:0];
        load_val                 = MIN_D + offset;
        strobe                   = (state_q == S_COUNT) && tif.rand_en && (pre_q == PRE_MAX);
    end

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        remaining_d = remaining_q;
        delay_ms_d  = delay_ms_q;

        if (tif.rand_rst) begin
            state_d     = S_IDLE;
            pre_d       = '0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (tif.rand_en) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    remaining_d = load_val;
                    delay_ms_d  = load_val;
                    pre_d       = '0;
                    state_d     = S_COUNT;
                end
                S_COUNT: begin
                    if (strobe) begin
                        pre_d = '0;
                        // <= 1 rather than == 1 so a zero delay fires instead of wrapping
                        if (remaining_q <= DW'(1)) begin
                            remaining_d = '0;
                            state_d     = S_FIRE;
                        end else begin
                            remaining_d = remaining_q - DW'(1);
                        end
                    end else if (tif.rand_en) begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                S_FIRE: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tif.rand_tick    = (state_q == S_FIRE);
        tif.busy         = (state_q == S_LOAD) || (state_q == S_COUNT) || (state_q == S_FIRE);
        tif.done         = (state_q == S_DONE);
        tif.delay_ms     = delay_ms_q;
        tif.ms_remaining = remaining_q;
    end
endmodule

// File: tb/tb_rand_delay_gen.sv
// tb/tb_rand_delay_gen.sv - self-checking bench for rand_delay_gen
module tb_rand_delay_gen;
    localparam int TPM = 4;
    localparam int MIN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_edges = 0;

    rand_delay_gen_if #(.DW(16)) tif ();

    rand_delay_gen #(
        .CLK_HZ(4000), .MIN_MS(3), .RANGE_LOG2(2), .LFSR_SEED(16'h0001), .DW(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tif(tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int arm_after;
        int pstart;
        int plen;
        int exp_d;
        int exp_t;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] v;
        v = 16'h0001;
        for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
        n_edges++;
    endtask

    task automatic reset_release(input logic en);
        rst_n        = 1'b0;
        tif.rand_en  = 1'b0;
        tif.rand_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        tif.rand_en = en;
        n_edges     = 0;
    endtask

    task automatic run_case(input string tag, input int arm_after, input int pstart,
                            input int plen, input int exp_d, input int exp_t);
        int   ticks;
        int   first;
        int   active;
        logic en_s;
        ticks  = 0;
        first  = -1;
        active = 0;
        reset_release(arm_after == 0);
        for (int i = 0; i < arm_after; i++) edge_wait();
        tif.rand_en = 1'b1;
        for (int rel = 0; rel <= exp_t + 6; rel++) begin
            en_s = tif.rand_en;
            edge_wait();
            if (rel >= 2 && en_s && active < exp_d * TPM) active++;
            if (tif.rand_tick) begin
                ticks++;
                if (first < 0) first = rel;
            end
            if (rel >= 1) chk({tag, " ms_remaining"}, 32'(tif.ms_remaining), 32'(exp_d - active / TPM));
            chk({tag, " busy"}, 32'(tif.busy), 32'(rel <= exp_t));
            chk({tag, " done"}, 32'(tif.done), 32'(rel > exp_t));
            tif.rand_en = !((rel + 1) >= pstart && (rel + 1) < pstart + plen);
        end
        chk({tag, " tick count"}, 32'(ticks), 32'd1);
        chk({tag, " tick edge"}, 32'(first), 32'(exp_t));
        chk({tag, " delay_ms"}, 32'(tif.delay_ms), 32'(exp_d));
    endtask

    initial begin
        int          ticks;
        int          arm, ps, pl, d, t, act;
        logic [15:0] lv;

        vecs[0] = '{arm_after: 0, pstart: 0, plen: 0, exp_d: 5, exp_t: 21};
        vecs[1] = '{arm_after: 2, pstart: 0, plen: 0, exp_d: 3, exp_t: 13};
        vecs[2] = '{arm_after: 0, pstart: 8, plen: 6, exp_d: 5, exp_t: 27};

        tif.rand_en  = 1'b0;
        tif.rand_rst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", 32'(tif.busy), 32'd0);
        chk("reset done", 32'(tif.done), 32'd0);
        chk("reset tick", 32'(tif.rand_tick), 32'd0);
        chk("reset delay_ms", 32'(tif.delay_ms), 32'd0);
        chk("reset ms_remaining", 32'(tif.ms_remaining), 32'd0);

        for (int v = 0; v < 3; v++)
            run_case($sformatf("vec%0d", v), vecs[v].arm_after, vecs[v].pstart,
                     vecs[v].plen, vecs[v].exp_d, vecs[v].exp_t);

        // Abort mid-count with rand_rst
        reset_release(1'b1);
        for (int i = 0; i < 10; i++) edge_wait();
        tif.rand_rst = 1'b1;
        tif.rand_en  = 1'b0;
        edge_wait();
        chk("abort busy", 32'(tif.busy), 32'd0);
        chk("abort ms_remaining", 32'(tif.ms_remaining), 32'd0);
        chk("abort delay_ms kept", 32'(tif.delay_ms), 32'd5);
        tif.rand_rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            edge_wait();
            if (tif.rand_tick || tif.busy) ticks++;
        end
        chk("abort no activity", 32'(ticks), 32'd0);

        // Asynchronous reset between edges mid-count
        reset_release(1'b1);
        for (int i = 0; i < 10; i++) edge_wait();
        #3 rst_n = 1'b0;
        #1;
        chk("async busy", 32'(tif.busy), 32'd0);
        chk("async done", 32'(tif.done), 32'd0);
        chk("async tick", 32'(tif.rand_tick), 32'd0);
        chk("async delay_ms", 32'(tif.delay_ms), 32'd0);
        chk("async ms_remaining", 32'(tif.ms_remaining), 32'd0);
        run_case("after_async", 0, 0, 0, 5, 21);

        // Held in DONE with rand_en high: no re-arm until rand_rst
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            edge_wait();
            if (tif.rand_tick) ticks++;
        end
        chk("done hold ticks", 32'(ticks), 32'd0);
        chk("done hold done", 32'(tif.done), 32'd1);
        tif.rand_rst = 1'b1;
        edge_wait();
        edge_wait();
        chk("rst+en stays idle busy", 32'(tif.busy), 32'd0);
        chk("rst+en stays idle done", 32'(tif.done), 32'd0);
        tif.rand_rst = 1'b0;
        edge_wait();
        lv = lfsr_at(n_edges);
        chk("rearm busy", 32'(tif.busy), 32'd1);
        edge_wait();
        chk("rearm delay_ms", 32'(tif.delay_ms), 32'(MIN + int'(lv[1:0])));
        chk("rearm ms_remaining", 32'(tif.ms_remaining), 32'(MIN + int'(lv[1:0])));

        // Randomized arm times and pauses against the arithmetic model
        for (int k = 0; k < 8; k++) begin
            arm = $urandom_range(0, 12);
            pl  = $urandom_range(0, 8);
            ps  = $urandom_range(1, 20);
            lv  = lfsr_at(arm + 1);
            d   = MIN + int'(lv[1:0]);
            act = 0;
            t   = 1;
            while (act < d * TPM) begin
                t++;
                if (!(t >= ps && t < ps + pl)) act++;
            end
            run_case($sformatf("rnd%0d", k), arm, ps, pl, d, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rand_delay_gen.md
Name: rand_delay_gen

Overview:
- Random-interval timer directly upstream of the reaction-game control FSM.
- Consumes that FSM's `rand_en` / `rand_rst` and produces its single-cycle `rand_tick`, which ends the wait phase.
- Delay is MIN_MS plus a pseudo-random offset drawn from a free-running LFSR. Because the LFSR runs every cycle, the delay depends on when the player pressed start.

Parameters:
- CLK_HZ, 100_000_000, clock frequency. TPM = CLK_HZ/1000 clock cycles per millisecond; TPM ≥ 1.
- MIN_MS, 1000, minimum delay in ms.
- RANGE_LOG2, 12, random offset width; offset range is 0..2^RANGE_LOG2-1 ms. Must be ≤ 16.
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is forced to 16'h0001.
- DW, 16, delay/remaining width. MIN_MS + 2^RANGE_LOG2 - 1 must fit in DW bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rand_en  in  1  enable: arms the timer from IDLE; low pauses counting
- rand_rst  in  1  synchronous abort/clear; highest priority after rst_n
- rand_tick  out  1  one-cycle pulse when the delay expires
- busy  out  1  high in LOAD, COUNT and FIRE
- done  out  1  high in DONE
- delay_ms  out  DW  delay captured at the last LOAD (debug/display)
- ms_remaining  out  DW  milliseconds left in the current countdown

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, lfsr=LFSR_SEED, pre=0, remaining=0, delay_ms=0.
  - rand_tick=0, busy=0, done=0.
- LFSR:
  - 16-bit Fibonacci register, fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], next = {lfsr[14:0], fb}.
  - Advances on every clock edge out of reset, regardless of state, rand_en or rand_rst.
  - Never reaches 0.
- Prescaler `pre`: 0..TPM-1, increments only in COUNT with rand_en=1. strobe = (pre==TPM-1) in that condition; on strobe, pre wraps to 0.
- States:
  - IDLE: if rand_en=1 and rand_rst=0, go to LOAD.
  - LOAD (1 cycle):
    - D = MIN_MS + lfsr[RANGE_LOG2-1:0], using the lfsr value present during the LOAD cycle.
    - Set remaining=D, delay_ms=D, pre=0; go to COUNT.
  - COUNT:
    - rand_en=0: hold pre and remaining (pause).
    - On strobe: remaining -= 1.
    - If strobe and remaining==1: go to FIRE; remaining becomes 0.
  - FIRE (1 cycle): rand_tick=1; go to DONE.
  - DONE: done=1, rand_tick=0; hold until rand_rst.
- rand_rst=1 sampled in any state:
  - Next state IDLE, pre=0, remaining=0, no tick.
  - delay_ms and lfsr are not cleared.
  - rand_rst=1 and rand_en=1 together: the timer stays in IDLE.
- Outputs: rand_tick, busy and done are decoded from the registered state only (no input-to-output combinational path). ms_remaining = remaining.
- Timing: edge 0 is the edge at which IDLE samples rand_en=1.
  - LOAD completes at edge 1.
  - The D-th strobe occurs at edge 1+D·TPM (no pauses).
  - rand_tick is high exactly in the cycle following edge 1+D·TPM.
  - Each paused cycle adds 1 cycle.
- rand_en falling in DONE: no effect. rand_en high in DONE: no re-arm without rand_rst.

Test Plan:
1. CLK_HZ=4000 (TPM=4), MIN_MS=3, RANGE_LOG2=2, LFSR_SEED=1; rand_en=1 from reset release. → lfsr=0x0002 in LOAD, delay_ms=5; rand_tick single pulse after edge 21; done=1 afterward; busy=0 once in DONE.
2. Same config, rand_en raised so that edge 0 is the 3rd edge after release. → lfsr=0x0008 in LOAD, delay_ms=3; rand_tick after edge 13 (relative to edge 0); ms_remaining steps 3,2,1,0 at edges 5,9,13.
3. Case 1, rand_rst=1 for one cycle at edge 10. → state IDLE next cycle; busy=0, ms_remaining=0; no rand_tick for 40 further cycles with rand_en=0.
4. Case 1, rand_en low for 6 cycles starting edge 8. → pre and ms_remaining frozen during the pause; rand_tick after edge 27.
5. Assert rst_n=0 asynchronously mid-COUNT (not at a clock edge). → all outputs 0 immediately; after release lfsr restarts at seed and case 1 timing repeats exactly.
6. In DONE, hold rand_en=1 for 50 cycles, then pulse rand_rst. → no second tick; returns to IDLE and re-arms on the next rand_en.
